// File: rtl/mem_stream_writer.sv
// Streams a contiguous burst of valid/ready words into a single-port memory write
// interface. The optional checksum port is enabled with `define MEM_STREAM_WRITER_CHECKSUM_EN.
module mem_stream_writer #(
    parameter int width = 5,
    parameter int depth = 4,
    localparam int AW = $clog2(depth)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      count,
    input  logic             in_valid,
    input  logic [width-1:0] in_data,
    output logic             in_ready,
    output logic [width-1:0] wdata,
    output logic [AW-1:0]    waddr,
    output logic             wen,
    output logic             busy,
    output logic             done
`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
    ,
    output logic [width-1:0] checksum
`endif
);

    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(depth);
    localparam logic [AW-1:0] LAST_ADDR = AW'(depth - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     addr, addr_nxt;
    logic [AW:0]       remaining, remaining_nxt;
    logic              start_acc;
    logic              handshake;

    function automatic logic [AW:0] sat_count(input logic [AW:0] c);
        return (c > DEPTH_CNT) ? DEPTH_CNT : c;
    endfunction

    function automatic logic [AW-1:0] legal_base(input logic [AW-1:0] b);
        return ({1'b0, b} < DEPTH_CNT) ? b : '0;
    endfunction

    // Explicit compare keeps the wrap correct for non-power-of-2 depths.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + AW'(1);
    endfunction

    assign start_acc = (state == S_IDLE) && start;
    assign handshake = in_ready && in_valid;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        remaining_nxt = remaining;
        in_ready      = 1'b0;
        wen           = 1'b0;
        wdata         = '0;
        waddr         = '0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_acc) begin
                    if (count == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt     = S_WRITE;
                        addr_nxt      = legal_base(base_addr);
                        remaining_nxt = sat_count(count);
                    end
                end
            end
            S_WRITE: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                wen      = handshake;
                waddr    = addr;
                if (handshake) begin
                    wdata         = in_data;
                    addr_nxt      = next_addr(addr);
                    remaining_nxt = remaining - (AW + 1)'(1);
                    if (remaining == (AW + 1)'(1)) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
    always_ff @(posedge clk or posedge arst) begin
        if (arst)           checksum <= '0;
        else if (start_acc) checksum <= '0;
        else if (handshake) checksum <= checksum ^ in_data;
    end
`endif

endmodule

// File: tb/tb_mem_stream_writer.sv
// Bench for mem_stream_writer: directed and randomized bursts against a burst-level
// reference model and a behavioural memory; covers MEM_STREAM_WRITER_CHECKSUM_EN when defined.
module tb_mem_stream_writer;

    localparam int W  = 5;
    localparam int D  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          arst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic [W-1:0]  wdata;
    logic [AW-1:0] waddr;
    logic          wen;
    logic          busy;
    logic          done;
`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
    logic [W-1:0]  checksum;
`endif

    int errors = 0;
    int checks = 0;

    logic [W-1:0] tb_mem    [D] = '{default: '1};
    logic [W-1:0] model_mem [D] = '{default: '1};
    logic [W-1:0] model_cs;
    logic [W-1:0] data_q [$];
    bit           vld_q  [$];

    mem_stream_writer #(.width(W), .depth(D)) dut (
        .clk       (clk),
        .arst      (arst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wdata     (wdata),
        .waddr     (waddr),
        .wen       (wen),
        .busy      (busy),
        .done      (done)
`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the memory's write port.
    always @(posedge clk) begin
        if (wen) tb_mem[waddr] <= wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_mem(input string tag);
        for (int i = 0; i < D; i++) chk($sformatf("%s_mem%0d", tag, i), tb_mem[i], model_mem[i]);
    endtask

    // One burst: start cycle, write phase until min(cnt,depth) words accepted, done cycle, idle cycle.
    task automatic burst(input string tag, input int base, input int cnt,
                         input bit rand_vld, input bit poke_start);
        int n;
        int eb;
        int idx;
        int cyc;
        int a;
        bit v;
        logic [W-1:0] d;
        n   = (cnt > D) ? D : cnt;
        eb  = (base >= D) ? 0 : base;
        idx = 0;
        cyc = 0;
        model_cs = '0;
        @(negedge clk);
        start = 1'b1; base_addr = AW'(base); count = (AW + 1)'(cnt);
        in_valid = 1'b0; in_data = W'($urandom);
        #1;
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_ready"}, in_ready, 0);
        chk({tag, "_idle_wen"}, wen, 0);
        @(negedge clk);
        while (idx < n && cyc < 200) begin
            if (vld_q.size() > 0) v = vld_q.pop_front();
            else if (rand_vld)    v = 1'($urandom_range(0, 1));
            else                  v = 1'b1;
            d = (data_q.size() > 0) ? data_q.pop_front() : W'($urandom);
            in_valid = v; in_data = d; start = poke_start;
            base_addr = AW'($urandom); count = (AW + 1)'($urandom);
            #1;
            chk({tag, "_wr_ready"}, in_ready, 1);
            chk({tag, "_wr_busy"}, busy, 1);
            chk({tag, "_wr_done"}, done, 0);
            chk({tag, "_wr_wen"}, wen, v);
`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
            if (cyc == 0) chk({tag, "_cs_clear"}, checksum, 0);
`endif
            if (v) begin
                a = (eb + idx) % D;
                chk({tag, "_waddr"}, waddr, a);
                chk({tag, "_wdata"}, wdata, d);
                model_mem[a] = d;
                model_cs ^= d;
                idx++;
            end else begin
                chk({tag, "_wdata_zero"}, wdata, 0);
            end
            @(negedge clk);
            cyc++;
        end
        if (idx < n) chk({tag, "_burst_timeout"}, idx, n);
        in_valid = 1'($urandom_range(0, 1)); start = 1'b1;
        #1;
        chk({tag, "_done_pulse"}, done, 1);
        chk({tag, "_done_busy"}, busy, 1);
        chk({tag, "_done_wen"}, wen, 0);
        chk({tag, "_done_ready"}, in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0;
        #1;
        chk({tag, "_after_done"}, done, 0);
        chk({tag, "_after_busy"}, busy, 0);
        chk({tag, "_after_wen"}, wen, 0);
`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
        chk({tag, "_checksum"}, checksum, model_cs);
`endif
        chk_mem(tag);
    endtask

    initial begin
        arst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
        in_valid = 1'b0; in_data = '0;
        #3;
        chk("rst_ready", in_ready, 0);
        chk("rst_wen", wen, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        @(negedge clk);
        arst = 1'b0; in_valid = 1'b1; in_data = 5'd9;
        @(negedge clk);
        #1;
        chk("idle_no_wen", wen, 0);
        chk("idle_no_busy", busy, 0);
        in_valid = 1'b0;

        data_q = '{5'd11, 5'd21, 5'd0, 5'd5};
        burst("b0c4", 0, 4, 1'b0, 1'b0);
        chk("b0c4_m0", tb_mem[0], 11);
        chk("b0c4_m1", tb_mem[1], 21);
        chk("b0c4_m2", tb_mem[2], 0);
        chk("b0c4_m3", tb_mem[3], 5);
`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
        chk("b0c4_cs27", checksum, 27);
`endif

        data_q = '{5'd1, 5'd2, 5'd3};
        burst("wrap", 3, 3, 1'b0, 1'b0);
        chk("wrap_m3", tb_mem[3], 1);
        chk("wrap_m0", tb_mem[0], 2);
        chk("wrap_m1", tb_mem[1], 3);

        burst("cnt0", 2, 0, 1'b0, 1'b0);
        burst("cnt7", 1, 7, 1'b0, 1'b0);

        vld_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        burst("gaps", 0, 4, 1'b0, 1'b1);

        for (int i = 0; i < 12; i++)
            burst($sformatf("rnd%0d", i), $urandom_range(0, D - 1), $urandom_range(0, 7), 1'b1, 1'b1);

        // Abort a burst after two words with an asynchronous reset in mid-cycle.
        @(negedge clk);
        start = 1'b1; base_addr = '0; count = 3'd4; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = W'(5'd20 + 5'(i));
            model_mem[i] = in_data;
            @(negedge clk);
        end
        in_valid = 1'b1; in_data = 5'd30;
        #1;
        chk("abort_wen_before", wen, 1);
        #2;
        arst = 1'b1;
        #1;
        chk("abort_wen", wen, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 0);
        chk("abort_done", done, 0);
        chk("abort_waddr", waddr, 0);
`ifdef MEM_STREAM_WRITER_CHECKSUM_EN
        chk("abort_cs", checksum, 0);
`endif
        @(negedge clk);
        arst = 1'b0;
        #1;
        chk("abort_rel_wen", wen, 0);
        chk("abort_rel_done", done, 0);
        @(negedge clk);
        #1;
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_done", done, 0);
        in_valid = 1'b0;
        chk_mem("abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
